// File: rtl/fram_timing_gen.sv
// fram_timing_gen
//   Free-running frame counter that follows upstream frame heads. It tracks
//   lock with a SEARCH/CHECK/LOCK state machine and issues a delayed copy of
//   the frame head.
//
//   Parameters
//     FRAM_MAX    last count value of a frame (period = FRAM_MAX+1 clocks)
//     LOCK_NUM    consecutive on-period heads needed to declare lock
//     UNLOCK_NUM  consecutive bad events that drop lock
//
//   Ports
//     clk         sole clock, rising edge
//     rst         asynchronous active-high reset
//     i_fram_hd   one-clock frame-head pulse
//     i_delay     head-to-delayed-head offset in clocks
//     i_err_clr   synchronous clear of o_err_cnt
//     o_fram_cnt  position of the current clock within the frame
//     o_delay_hd  one-clock delayed frame-head pulse
//     o_lock      high while the state machine is in LOCK
//     o_err_cnt   saturating count of bad events seen while not searching
module fram_timing_gen #(
  parameter logic [25:0] FRAM_MAX   = 26'd4915199,
  parameter logic [3:0]  LOCK_NUM   = 4'd3,
  parameter logic [3:0]  UNLOCK_NUM = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fram_hd,
  input  logic [25:0] i_delay,
  input  logic        i_err_clr,
  output logic [25:0] o_fram_cnt,
  output logic        o_delay_hd,
  output logic        o_lock,
  output logic [15:0] o_err_cnt
);

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCK
  } state_t;

  state_t      state_q, state_d;
  logic [25:0] cnt_q, cnt_d;
  logic [25:0] delay_sh_q, delay_sh_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic [3:0]  bad_cnt_q, bad_cnt_d;
  logic        delay_hd_q, delay_hd_d;
  logic        lock_q, lock_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        cnt_at_max;
  logic        good_hd;
  logic        bad_evt;
  logic [3:0]  good_inc;
  logic [3:0]  bad_inc;

  // Event classification. The counter never exceeds FRAM_MAX, so any head
  // that arrives with the counter below the end value is an early head.
  always_comb begin
    cnt_at_max = (cnt_q == FRAM_MAX);
    good_hd    = i_fram_hd && cnt_at_max;
    bad_evt    = (i_fram_hd && !cnt_at_max) || (!i_fram_hd && cnt_at_max);
    good_inc   = good_cnt_q + 4'd1;
    bad_inc    = bad_cnt_q + 4'd1;
  end

  // State register and all output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEARCH;
      cnt_q      <= '0;
      delay_sh_q <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      delay_hd_q <= 1'b0;
      lock_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      delay_sh_q <= delay_sh_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      delay_hd_q <= delay_hd_d;
      lock_q     <= lock_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    unique case (state_q)
      SEARCH: begin
        // Any head, early or not, restarts qualification.
        if (i_fram_hd) begin
          state_d    = CHECK;
          good_cnt_d = '0;
        end
      end
      CHECK: begin
        if (bad_evt) begin
          state_d = SEARCH;
        end else if (good_hd) begin
          good_cnt_d = good_inc;
          if (good_inc >= LOCK_NUM) begin
            state_d   = LOCK;
            bad_cnt_d = '0;
          end
        end
      end
      LOCK: begin
        if (bad_evt) begin
          bad_cnt_d = bad_inc;
          if (bad_inc >= UNLOCK_NUM) begin
            state_d = SEARCH;
          end
        end else if (good_hd) begin
          bad_cnt_d = '0;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // Output / datapath logic
  always_comb begin
    // Counter phase follows every head regardless of state.
    if (i_fram_hd || cnt_at_max) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 26'd1;
    end

    delay_sh_d = delay_sh_q;
    if (i_fram_hd) begin
      delay_sh_d = (i_delay > FRAM_MAX) ? FRAM_MAX : i_delay;
    end

    delay_hd_d = (state_q != SEARCH) && (cnt_q == delay_sh_q);

    // Decoded from the next state so o_lock lines up with the LOCK state
    // while still coming straight from a flop.
    lock_d = (state_d == LOCK);

    err_cnt_d = err_cnt_q;
    if (i_err_clr) begin
      err_cnt_d = '0;
    end else if (bad_evt && (state_q != SEARCH) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  assign o_fram_cnt = cnt_q;
  assign o_delay_hd = delay_hd_q;
  assign o_lock     = lock_q;
  assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_fram_timing_gen.sv
// Directed testbench for fram_timing_gen.
//   u_dut : FRAM_MAX=99, LOCK_NUM=3, UNLOCK_NUM=2 for the frame/lock scenarios.
//   u_sat : FRAM_MAX=0, LOCK_NUM=1, UNLOCK_NUM=15. Every clock without a head
//           is then a miss, which drives the error counter to saturation
//           quickly.
// Cycle k is the clock period after edge k. Inputs set in cycle k are
// sampled at the next edge, and outputs read #1 after edge k belong to cycle k.
module tb_fram_timing_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        hd = 1'b0;
  logic        clr = 1'b0;
  logic [25:0] dly = '0;
  logic [25:0] o_fram_cnt;
  logic        o_delay_hd;
  logic        o_lock;
  logic [15:0] o_err_cnt;

  logic        rst2 = 1'b1;
  logic        hd2 = 1'b0;
  logic        clr2 = 1'b0;
  logic [25:0] dly2 = '0;
  logic [25:0] d2_cnt;
  logic        d2_dly;
  logic        d2_lock;
  logic [15:0] d2_err;

  fram_timing_gen #(
    .FRAM_MAX  (26'd99),
    .LOCK_NUM  (4'd3),
    .UNLOCK_NUM(4'd2)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .i_fram_hd (hd),
    .i_delay   (dly),
    .i_err_clr (clr),
    .o_fram_cnt(o_fram_cnt),
    .o_delay_hd(o_delay_hd),
    .o_lock    (o_lock),
    .o_err_cnt (o_err_cnt)
  );

  fram_timing_gen #(
    .FRAM_MAX  (26'd0),
    .LOCK_NUM  (4'd1),
    .UNLOCK_NUM(4'd15)
  ) u_sat (
    .clk       (clk),
    .rst       (rst2),
    .i_fram_hd (hd2),
    .i_delay   (dly2),
    .i_err_clr (clr2),
    .o_fram_cnt(d2_cnt),
    .o_delay_hd(d2_dly),
    .o_lock    (d2_lock),
    .o_err_cnt (d2_err)
  );

  int checks = 0;
  int errors = 0;

  logic        hd_sched [0:1023];
  logic [25:0] cnt_tr   [0:1023];
  logic        dly_tr   [0:1023];
  logic        lock_tr  [0:1023];
  logic [15:0] err_tr   [0:1023];
  logic [25:0] dly_a, dly_b;
  int          dly_sw;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    hd     = 1'b0;
    clr    = 1'b0;
    dly    = '0;
    dly_a  = '0;
    dly_b  = '0;
    dly_sw = 0;
    for (int i = 0; i < 1024; i++) hd_sched[i] = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drives heads from hd_sched and records outputs for cycles 0..n-1.
  task automatic run_seq(input int n);
    for (int c = 0; c < n; c++) begin
      hd          = hd_sched[c];
      dly         = (c < dly_sw) ? dly_a : dly_b;
      cnt_tr[c]   = o_fram_cnt;
      dly_tr[c]   = o_delay_hd;
      lock_tr[c]  = o_lock;
      err_tr[c]   = o_err_cnt;
      step();
    end
    hd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hd  = 1'b1;
    dly = 26'd5;
    step();
    step();
    checks++; if (o_fram_cnt !== 26'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", o_fram_cnt); end
    checks++; if (o_delay_hd !== 1'b0) begin errors++; $display("FAIL rst_dly: got %0d want 0", o_delay_hd); end
    checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL rst_lock: got %0d want 0", o_lock); end
    checks++; if (o_err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err: got %0h want 0", o_err_cnt); end
    do_reset();
    run_seq(5);
    checks++; if (cnt_tr[0] !== 26'd0) begin errors++; $display("FAIL post_rst_cnt0: got %0d want 0", cnt_tr[0]); end
    checks++; if (cnt_tr[4] !== 26'd4) begin errors++; $display("FAIL post_rst_cnt4: got %0d want 4", cnt_tr[4]); end
  endtask

  task automatic test_lock_acquire();
    int np;
    do_reset();
    dly_a = 26'd10; dly_b = 26'd10;
    hd_sched[0] = 1'b1; hd_sched[100] = 1'b1; hd_sched[200] = 1'b1; hd_sched[300] = 1'b1;
    run_seq(320);
    np = 0;
    for (int c = 0; c < 320; c++) if (dly_tr[c] === 1'b1) np++;
    checks++; if (np !== 4) begin errors++; $display("FAIL acq_pulse_count: got %0d want 4", np); end
    checks++; if ({dly_tr[12], dly_tr[112], dly_tr[212], dly_tr[312]} !== 4'b1111) begin errors++; $display("FAIL acq_pulse_pos: got %b want 1111", {dly_tr[12], dly_tr[112], dly_tr[212], dly_tr[312]}); end
    checks++; if (cnt_tr[1] !== 26'd0) begin errors++; $display("FAIL acq_cnt1: got %0d want 0", cnt_tr[1]); end
    checks++; if (cnt_tr[100] !== 26'd99) begin errors++; $display("FAIL acq_cnt100: got %0d want 99", cnt_tr[100]); end
    checks++; if (lock_tr[300] !== 1'b0) begin errors++; $display("FAIL acq_lock300: got %0d want 0", lock_tr[300]); end
    checks++; if (lock_tr[301] !== 1'b1) begin errors++; $display("FAIL acq_lock301: got %0d want 1", lock_tr[301]); end
    checks++; if (err_tr[319] !== 16'd0) begin errors++; $display("FAIL acq_err: got %0h want 0", err_tr[319]); end
  endtask

  task automatic test_single_miss();
    do_reset();
    dly_a = 26'd10; dly_b = 26'd10;
    hd_sched[0] = 1'b1; hd_sched[100] = 1'b1; hd_sched[200] = 1'b1; hd_sched[300] = 1'b1;
    hd_sched[500] = 1'b1; hd_sched[700] = 1'b1;
    run_seq(720);
    checks++; if (err_tr[400] !== 16'd0) begin errors++; $display("FAIL miss_err400: got %0h want 0", err_tr[400]); end
    checks++; if (err_tr[401] !== 16'd1) begin errors++; $display("FAIL miss_err401: got %0h want 1", err_tr[401]); end
    checks++; if (lock_tr[401] !== 1'b1) begin errors++; $display("FAIL miss_lock401: got %0d want 1", lock_tr[401]); end
    checks++; if (dly_tr[412] !== 1'b1) begin errors++; $display("FAIL miss_dly412: got %0d want 1", dly_tr[412]); end
    checks++; if (dly_tr[512] !== 1'b1) begin errors++; $display("FAIL miss_dly512: got %0d want 1", dly_tr[512]); end
    // A second isolated miss only stays locked if the head at 500 cleared bad_cnt.
    checks++; if (err_tr[601] !== 16'd2) begin errors++; $display("FAIL miss_err601: got %0h want 2", err_tr[601]); end
    checks++; if (lock_tr[601] !== 1'b1) begin errors++; $display("FAIL miss_lock601: got %0d want 1", lock_tr[601]); end
    checks++; if (lock_tr[710] !== 1'b1) begin errors++; $display("FAIL miss_lock710: got %0d want 1", lock_tr[710]); end
  endtask

  task automatic test_unlock();
    do_reset();
    dly_a = 26'd10; dly_b = 26'd10;
    hd_sched[0] = 1'b1; hd_sched[100] = 1'b1; hd_sched[200] = 1'b1; hd_sched[300] = 1'b1;
    run_seq(620);
    checks++; if (err_tr[401] !== 16'd1) begin errors++; $display("FAIL unl_err401: got %0h want 1", err_tr[401]); end
    checks++; if (lock_tr[500] !== 1'b1) begin errors++; $display("FAIL unl_lock500: got %0d want 1", lock_tr[500]); end
    checks++; if (lock_tr[501] !== 1'b0) begin errors++; $display("FAIL unl_lock501: got %0d want 0", lock_tr[501]); end
    checks++; if (err_tr[501] !== 16'd2) begin errors++; $display("FAIL unl_err501: got %0h want 2", err_tr[501]); end
    checks++; if (dly_tr[412] !== 1'b1) begin errors++; $display("FAIL unl_dly412: got %0d want 1", dly_tr[412]); end
    checks++; if (dly_tr[512] !== 1'b0) begin errors++; $display("FAIL unl_dly512: got %0d want 0", dly_tr[512]); end
    checks++; if (err_tr[619] !== 16'd2) begin errors++; $display("FAIL unl_err_search: got %0h want 2", err_tr[619]); end
  endtask

  task automatic test_early_head();
    do_reset();
    dly_a = 26'd10; dly_b = 26'd10;
    hd_sched[0] = 1'b1; hd_sched[100] = 1'b1; hd_sched[151] = 1'b1;
    hd_sched[251] = 1'b1; hd_sched[351] = 1'b1; hd_sched[451] = 1'b1; hd_sched[551] = 1'b1;
    run_seq(560);
    checks++; if (cnt_tr[151] !== 26'd50) begin errors++; $display("FAIL early_cnt151: got %0d want 50", cnt_tr[151]); end
    checks++; if (cnt_tr[152] !== 26'd0) begin errors++; $display("FAIL early_cnt152: got %0d want 0", cnt_tr[152]); end
    checks++; if (err_tr[152] !== 16'd1) begin errors++; $display("FAIL early_err152: got %0h want 1", err_tr[152]); end
    checks++; if (dly_tr[163] !== 1'b0) begin errors++; $display("FAIL early_dly163: got %0d want 0", dly_tr[163]); end
    checks++; if (dly_tr[263] !== 1'b1) begin errors++; $display("FAIL early_dly263: got %0d want 1", dly_tr[263]); end
    checks++; if (lock_tr[551] !== 1'b0) begin errors++; $display("FAIL early_lock551: got %0d want 0", lock_tr[551]); end
    checks++; if (lock_tr[552] !== 1'b1) begin errors++; $display("FAIL early_lock552: got %0d want 1", lock_tr[552]); end
    checks++; if (err_tr[559] !== 16'd1) begin errors++; $display("FAIL early_err_end: got %0h want 1", err_tr[559]); end
  endtask

  task automatic test_delay_clamp();
    int np;
    do_reset();
    dly_a = 26'd200; dly_b = 26'd5; dly_sw = 150;
    hd_sched[0] = 1'b1; hd_sched[100] = 1'b1; hd_sched[200] = 1'b1;
    run_seq(260);
    np = 0;
    for (int c = 0; c < 260; c++) if (dly_tr[c] === 1'b1) np++;
    checks++; if (np !== 3) begin errors++; $display("FAIL clamp_pulse_count: got %0d want 3", np); end
    checks++; if (dly_tr[100] !== 1'b0) begin errors++; $display("FAIL clamp_dly100: got %0d want 0", dly_tr[100]); end
    checks++; if (dly_tr[101] !== 1'b1) begin errors++; $display("FAIL clamp_dly101: got %0d want 1", dly_tr[101]); end
    checks++; if (cnt_tr[101] !== 26'd0) begin errors++; $display("FAIL clamp_cnt101: got %0d want 0", cnt_tr[101]); end
    checks++; if (dly_tr[201] !== 1'b1) begin errors++; $display("FAIL clamp_hold201: got %0d want 1", dly_tr[201]); end
    checks++; if (dly_tr[207] !== 1'b1) begin errors++; $display("FAIL clamp_new207: got %0d want 1", dly_tr[207]); end
  endtask

  task automatic test_async_reset();
    int nl;
    int nd;
    do_reset();
    dly_a = 26'd10; dly_b = 26'd10;
    hd_sched[0] = 1'b1; hd_sched[100] = 1'b1; hd_sched[200] = 1'b1; hd_sched[300] = 1'b1;
    hd_sched[305] = 1'b1;
    run_seq(317);
    checks++; if (o_fram_cnt !== 26'd11) begin errors++; $display("FAIL ar_pre_cnt: got %0d want 11", o_fram_cnt); end
    checks++; if (o_delay_hd !== 1'b1) begin errors++; $display("FAIL ar_pre_dly: got %0d want 1", o_delay_hd); end
    checks++; if (o_lock !== 1'b1) begin errors++; $display("FAIL ar_pre_lock: got %0d want 1", o_lock); end
    checks++; if (o_err_cnt !== 16'd1) begin errors++; $display("FAIL ar_pre_err: got %0h want 1", o_err_cnt); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (o_fram_cnt !== 26'd0) begin errors++; $display("FAIL ar_cnt: got %0d want 0", o_fram_cnt); end
    checks++; if (o_delay_hd !== 1'b0) begin errors++; $display("FAIL ar_dly: got %0d want 0", o_delay_hd); end
    checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL ar_lock: got %0d want 0", o_lock); end
    checks++; if (o_err_cnt !== 16'd0) begin errors++; $display("FAIL ar_err: got %0h want 0", o_err_cnt); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) hd_sched[i] = 1'b0;
    run_seq(250);
    nl = 0;
    nd = 0;
    for (int c = 0; c < 250; c++) begin
      if (lock_tr[c] === 1'b1) nl++;
      if (dly_tr[c] === 1'b1) nd++;
    end
    checks++; if (nl !== 0) begin errors++; $display("FAIL ar_post_lock: got %0d want 0", nl); end
    checks++; if (nd !== 0) begin errors++; $display("FAIL ar_post_dly: got %0d want 0", nd); end
    checks++; if (err_tr[249] !== 16'd0) begin errors++; $display("FAIL ar_post_err: got %0h want 0", err_tr[249]); end
    checks++; if (cnt_tr[100] !== 26'd0) begin errors++; $display("FAIL ar_post_wrap: got %0d want 0", cnt_tr[100]); end
  endtask

  // Each group is 14 misses then one good head, which keeps u_sat locked.
  task automatic test_err_saturate();
    rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0;
    hd2 = 1'b1;
    step();
    step();
    checks++; if (d2_lock !== 1'b1) begin errors++; $display("FAIL sat_lock: got %0d want 1", d2_lock); end
    for (int g = 0; g < 4681; g++) begin
      hd2 = 1'b0;
      repeat (14) step();
      hd2 = 1'b1;
      step();
    end
    checks++; if (d2_err !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %0h want fffe", d2_err); end
    for (int g = 0; g < 2; g++) begin
      hd2 = 1'b0;
      repeat (14) step();
      hd2 = 1'b1;
      step();
    end
    checks++; if (d2_err !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %0h want ffff", d2_err); end
    checks++; if (d2_lock !== 1'b1) begin errors++; $display("FAIL sat_lock_hold: got %0d want 1", d2_lock); end
    checks++; if (d2_cnt !== 26'd0) begin errors++; $display("FAIL sat_cnt: got %0d want 0", d2_cnt); end
    checks++; if (d2_dly !== 1'b1) begin errors++; $display("FAIL sat_dly: got %0d want 1", d2_dly); end
    hd2  = 1'b0;
    clr2 = 1'b1;
    step();
    clr2 = 1'b0;
    checks++; if (d2_err !== 16'd0) begin errors++; $display("FAIL sat_clr_wins: got %0h want 0", d2_err); end
    step();
    checks++; if (d2_err !== 16'd1) begin errors++; $display("FAIL sat_after_clr: got %0h want 1", d2_err); end
    hd2 = 1'b1;
    step();
    hd2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_single_miss();
    test_unlock();
    test_early_head();
    test_delay_clamp();
    test_async_reset();
    test_err_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fram_timing_gen.md
FRAM_TIMING_GEN -- requirements
Module: fram_timing_gen

Interface
REQ-001 Parameter FRAM_MAX, default 26'd4915199: last count value of one frame; frame period is FRAM_MAX+1 clocks.
REQ-002 Parameter LOCK_NUM, default 4'd3: consecutive on-period heads required to declare lock.
REQ-003 Parameter UNLOCK_NUM, default 4'd2: consecutive bad events that drop lock.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 i_fram_hd  input  1  protected frame-head pulse from the upstream frame-protect stage; one clock wide.
REQ-007 i_delay  input  26  required head-to-delayed-head offset in clocks.
REQ-008 i_err_clr  input  1  synchronous clear of o_err_cnt.
REQ-009 o_fram_cnt  output  26  position of the current clock within the frame.
REQ-010 o_delay_hd  output  1  one-clock delayed frame-head pulse.
REQ-011 o_lock  output  1  high while the FSM is in LOCK.
REQ-012 o_err_cnt  output  16  saturating count of bad events.

Function
REQ-013 Frame counter cnt SHALL load 0 on the clock after i_fram_hd=1, load 0 after cnt==FRAM_MAX, and increment otherwise; o_fram_cnt equals cnt.
REQ-014 A head with cnt==FRAM_MAX SHALL be a good head; a head with cnt<FRAM_MAX SHALL be an early event; cnt==FRAM_MAX with no head SHALL be a miss event; early and miss are bad events.
REQ-015 Each head SHALL latch i_delay into delay_sh, clamped to FRAM_MAX when i_delay>FRAM_MAX; delay_sh holds between heads.
REQ-016 With state!=SEARCH, o_delay_hd SHALL be 1 on the clock after cnt==delay_sh, else 0; latency is head at cycle t -> o_delay_hd at t+2+delay_sh.
REQ-017 The FSM SHALL have states SEARCH, CHECK and LOCK, plus counters good_cnt and bad_cnt (4 bits each).
REQ-018 In SEARCH, any head SHALL move to CHECK with good_cnt=0; bad events are ignored.
REQ-019 In CHECK, a good head SHALL increment good_cnt; reaching LOCK_NUM SHALL move to LOCK with bad_cnt=0; any bad event SHALL move to SEARCH.
REQ-020 In LOCK, a bad event SHALL increment bad_cnt; reaching UNLOCK_NUM SHALL move to SEARCH; a good head SHALL clear bad_cnt.
REQ-021 An early head counts as a bad event and also restarts cnt (REQ-013); cnt phase SHALL follow the latest head in every state.
REQ-022 o_err_cnt SHALL increment on each bad event in CHECK or LOCK, saturate at 16'hFFFF, and clear on i_err_clr; clear SHALL win over a simultaneous increment.
REQ-023 o_lock SHALL be a registered decode of state==LOCK; all outputs SHALL be driven directly from flops.

Reset
REQ-024 While rst=1: cnt=0, delay_sh=0, state=SEARCH, good_cnt=0, bad_cnt=0, o_delay_hd=0, o_lock=0, o_err_cnt=0.
REQ-025 Reset mid-frame SHALL abort immediately; after release the block SHALL behave as from power-up and wait for a head in SEARCH.

Verification (FRAM_MAX=99, LOCK_NUM=3, UNLOCK_NUM=2)
REQ-026 Heads at cycles 0,100,200,300, i_delay=10 -> o_lock rises at 301; o_delay_hd pulses at 12,112,212,312; o_err_cnt=0.
REQ-027 Locked, head at 400 withheld, head at 500 present -> miss at cnt==99 (cycle 400); o_err_cnt=1; o_lock stays 1; bad_cnt cleared at 501.
REQ-028 Locked, heads at 400 and 500 both withheld -> o_lock falls after second miss (cycle 501); o_delay_hd stops; o_err_cnt=2.
REQ-029 In CHECK, early head at cnt==50 -> state SEARCH next clock; cnt=0; o_err_cnt=1; relock requires 1+3 further heads.
REQ-030 i_delay=200 -> delay_sh=99; o_delay_hd fires on the clock after cnt==99, coinciding with the next head's cnt reset.
REQ-031 o_err_cnt preloaded to FFFF by forced bad events -> remains FFFF; i_err_clr with a simultaneous bad event -> 0; rst asserted mid-frame -> all outputs 0 asynchronously.
